// File: rtl/trace_pkg.sv
// Shared types and constants for the instruction trace buffer.
package trace_pkg;

  localparam int unsigned TRACE_W = 48;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ARMED     = 2'd1,
    TRIGGERED = 2'd2,
    DONE      = 2'd3
  } trace_state_t;

  typedef struct packed {
    logic [15:0] pc;
    logic [15:0] instr;
    logic [15:0] alu;
  } trace_entry_t;

endpackage

// File: rtl/trace_mem.sv
// Trace storage: DEPTH x TRACE_W, one write port, one registered read port.
module trace_mem
  import trace_pkg::*;
#(
  parameter  int unsigned DEPTH = 16,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               we,
  input  logic [AW-1:0]      waddr,
  input  logic [TRACE_W-1:0] wdata,
  input  logic               re,
  input  logic [AW-1:0]      raddr,
  output logic [TRACE_W-1:0] rdata
);

  logic [TRACE_W-1:0] mem [DEPTH];

  // Array write; the array itself is never reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Synchronous read register, cleared by reset so rd_data reads zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/trace_buffer.sv
// Circular instruction trace buffer with PC trigger, post-trigger capture
// and oldest-first readout once frozen.
module trace_buffer
  import trace_pkg::*;
#(
  parameter  int unsigned DEPTH      = 16,
  parameter  int unsigned POST_COUNT = 8,
  localparam int unsigned AW         = $clog2(DEPTH),
  localparam int unsigned CW         = AW + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [15:0]        debug_pc,
  input  logic [15:0]        debug_instruction,
  input  logic [15:0]        debug_ALUResult,
  input  logic               trace_valid,
  input  logic               arm,
  input  logic [15:0]        trig_pc,
  input  logic               rd_en,
  output logic [TRACE_W-1:0] rd_data,
  output logic               rd_valid,
  output logic               rd_empty,
  output logic               done,
  output logic [1:0]         state,
  output logic [CW-1:0]      count
);

  trace_state_t st;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] post_cnt;
  logic [CW-1:0] unread;

  trace_entry_t  entry;
  logic          wr_fire;
  logic          rd_fire;
  logic [AW-1:0] wr_next;
  logic [CW-1:0] count_next;
  logic [AW-1:0] oldest;

  // Capture qualification and next-value helpers.
  always_comb begin
    entry       = '0;
    entry.pc    = debug_pc;
    entry.instr = debug_instruction;
    entry.alu   = debug_ALUResult;
    wr_fire     = (st == ARMED || st == TRIGGERED) && trace_valid && !arm;
    rd_fire     = (st == DONE) && rd_en && (unread != '0) && !arm;
    wr_next     = wr_ptr + 1'b1;
    count_next  = (count == CW'(DEPTH)) ? count : count + 1'b1;
    // Once wrapped, the slot about to be overwritten holds the oldest entry.
    oldest      = (count_next == CW'(DEPTH)) ? wr_next : '0;
  end

  // Capture/readout FSM with pointer and counter bookkeeping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st       <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      post_cnt <= '0;
      unread   <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_fire;
      if (arm) begin
        st       <= ARMED;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count    <= '0;
        post_cnt <= '0;
        unread   <= '0;
      end else begin
        case (st)
          ARMED: if (wr_fire) begin
            wr_ptr <= wr_next;
            count  <= count_next;
            if (debug_pc == trig_pc) begin
              if (POST_COUNT == 0) begin
                st     <= DONE;
                rd_ptr <= oldest;
                unread <= count_next;
              end else begin
                st       <= TRIGGERED;
                post_cnt <= CW'(POST_COUNT);
              end
            end
          end
          TRIGGERED: if (wr_fire) begin
            wr_ptr   <= wr_next;
            count    <= count_next;
            post_cnt <= post_cnt - 1'b1;
            if (post_cnt == CW'(1)) begin
              st     <= DONE;
              rd_ptr <= oldest;
              unread <= count_next;
            end
          end
          DONE: if (rd_fire) begin
            rd_ptr <= rd_ptr + 1'b1;
            unread <= unread - 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign state    = st;
  assign done     = (st == DONE);
  assign rd_empty = (st != DONE) || (unread == '0);

  trace_mem #(.DEPTH(DEPTH)) u_mem (
    .clk   (clk),
    .reset (reset),
    .we    (wr_fire),
    .waddr (wr_ptr),
    .wdata (entry),
    .re    (rd_fire),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

endmodule

// File: doc/trace_buffer.md
TRACE_BUFFER -- requirements
Module: trace_buffer

Interface
REQ-001 Parameter DEPTH, default 16, number of trace entries; power of two, 4..64.
REQ-002 Parameter POST_COUNT, default 8, entries captured after the trigger entry; 0..DEPTH-1.
REQ-003 clk  input  1  single clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 debug_pc  input  16  processor PC of the retiring instruction.
REQ-006 debug_instruction  input  16  processor instruction word.
REQ-007 debug_ALUResult  input  16  processor ALU result.
REQ-008 trace_valid  input  1  the three debug buses hold a retired instruction this cycle.
REQ-009 arm  input  1  single-cycle pulse that clears the buffer and starts capture.
REQ-010 trig_pc  input  16  PC value that fires the trigger.
REQ-011 rd_en  input  1  readout request, one entry per asserted cycle.
REQ-012 rd_data  output  48  entry {pc, instruction, ALUResult}; pc in bits 47:32.
REQ-013 rd_valid  output  1  rd_data valid this cycle.
REQ-014 rd_empty  output  1  no unread entries remain (DONE state only).
REQ-015 done  output  1  capture finished; the buffer is frozen.
REQ-016 state  output  2  current FSM state.
REQ-017 count  output  $clog2(DEPTH)+1  number of valid entries held, saturating at DEPTH.

Function
REQ-018 The FSM SHALL have four states: IDLE=0, ARMED=1, TRIGGERED=2, DONE=3.
REQ-019 An arm pulse in any state SHALL clear wr_ptr, rd_ptr and count and go to ARMED next cycle; the entry presented in the arm cycle SHALL NOT be captured.
REQ-020 ARMED: each trace_valid cycle SHALL write the entry at wr_ptr; wr_ptr increments modulo DEPTH; count increments, saturating at DEPTH (the oldest entry is overwritten).
REQ-021 ARMED with trace_valid and debug_pc==trig_pc: SHALL write that entry and move to TRIGGERED with post counter=POST_COUNT, or straight to DONE if POST_COUNT==0.
REQ-022 TRIGGERED: each trace_valid cycle SHALL write one entry and decrement the post counter; the write that brings it to 0 SHALL move the FSM to DONE. Further PC matches are ignored.
REQ-023 IDLE and DONE: trace_valid SHALL be ignored and no writes occur.
REQ-024 On entry to DONE, rd_ptr SHALL point to the oldest entry: wr_ptr if count==DEPTH, else 0.
REQ-025 DONE with rd_en and !rd_empty: rd_data and rd_valid=1 SHALL appear the next cycle (1-cycle latency). rd_ptr advances modulo DEPTH and the unread counter decrements.
REQ-026 rd_en SHALL be ignored outside DONE or when rd_empty=1; rd_valid stays 0.
REQ-027 rd_empty=1 when the unread counter is 0 in DONE, and rd_empty=1 in every other state; done=1 exactly in DONE.
REQ-028 The readout order SHALL run oldest to newest; the last entry read is the final post-trigger entry.

Reset
REQ-029 Asserting reset (low) SHALL immediately force state=IDLE, done=0, count=0, rd_valid=0, rd_empty=1, rd_data=0, and clear all pointers and counters; memory contents are don't-care.
REQ-030 Reset asserted mid-capture or mid-readout SHALL abort the operation with no partial write. The first arm after deassertion SHALL behave per REQ-019.

Structure
REQ-031 Package trace_pkg SHALL hold the state enum, the TRACE_W=48 constant and the trace entry struct {pc, instr, alu}.
REQ-032 Storage SHALL be a sub-module trace_mem: DEPTH x TRACE_W, one write port and one synchronous read port, no reset on the array.

Verification
REQ-033 Arm; 5 trace_valid with pc 0x0000..0x0004, trig_pc=0x0002, POST_COUNT=2 -> DONE after pc 0x0004, count=5; readout gives pc 0..4 in order, then rd_empty=1.
REQ-034 DEPTH=16, POST_COUNT=8; 30 entries pc=0x0000..0x001D, trigger at 0x0015 -> count=16; readout starts at pc 0x000E and ends at 0x001D.
REQ-035 trig_pc=0x0000, POST_COUNT=0, first entry pc=0x0000 -> DONE next cycle, count=1, a single readout returns that entry.
REQ-036 In DONE with 3 unread entries, assert rd_en for 5 cycles -> exactly 3 rd_valid pulses with 1-cycle latency, then rd_empty=1.
REQ-037 Arm coincident with trace_valid, and a second arm during TRIGGERED -> the coincident entry is dropped, count returns to 0, state=ARMED.
REQ-038 Drive reset low asynchronously mid-TRIGGERED -> outputs reach reset values before the next clk edge; state=IDLE.
